// File: rtl/ping_pong_arbiter_if.sv
// Handshake bundle between two requesters and the ping-pong arbiter.
// The arbiter takes the slave modport. The requester side, or a bench, takes master.
interface ping_pong_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic       done_a;
  logic       done_b;
  logic       grant_a;
  logic       grant_b;
  logic       busy;
  logic       timeout_err;
  logic [7:0] grant_count;

  modport master (
    output req_a, req_b, done_a, done_b,
    input  grant_a, grant_b, busy, timeout_err, grant_count
  );

  modport slave (
    input  req_a, req_b, done_a, done_b,
    output grant_a, grant_b, busy, timeout_err, grant_count
  );
endinterface

// File: rtl/ping_pong_arbiter.sv
// Two-requester round-robin arbiter with a bounded hold time.
// Every grant is followed by a one-cycle RELEASE gap.
module ping_pong_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  ping_pong_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, RELEASE} state_e;
  typedef enum logic {OWN_A, OWN_B} owner_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] grant_count_q, grant_count_d;
  logic       grant_a_q, grant_a_d;
  logic       grant_b_q, grant_b_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic       force_rel;
  logic       grant_entry;

  // State register. All outputs are registered here as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_owner_q  <= OWN_B;
      hold_cnt_q    <= 8'd0;
      grant_count_q <= 8'd0;
      grant_a_q     <= 1'b0;
      grant_b_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_count_q <= grant_count_d;
      grant_a_q     <= grant_a_d;
      grant_b_q     <= grant_b_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic. A release (done or withdrawn request) takes priority
  // over a hold-time expiry, so a late done never raises a timeout error.
  always_comb begin
    state_d   = state_q;
    force_rel = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b)
          state_d = (last_owner_q == OWN_A) ? GRANT_B : GRANT_A;
        else if (bus.req_a)
          state_d = GRANT_A;
        else if (bus.req_b)
          state_d = GRANT_B;
      end
      GRANT_A: begin
        if (bus.done_a || !bus.req_a) begin
          state_d = RELEASE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = RELEASE;
          force_rel = 1'b1;
        end
      end
      GRANT_B: begin
        if (bus.done_b || !bus.req_b) begin
          state_d = RELEASE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = RELEASE;
          force_rel = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values, all derived from the transition taken.
  always_comb begin
    grant_entry   = (state_q == IDLE) && (state_d == GRANT_A || state_d == GRANT_B);
    grant_a_d     = (state_d == GRANT_A);
    grant_b_d     = (state_d == GRANT_B);
    busy_d        = (state_d != IDLE);
    timeout_d     = force_rel;
    last_owner_d  = last_owner_q;
    grant_count_d = grant_count_q;
    hold_cnt_d    = 8'd0;
    if (grant_entry) begin
      last_owner_d  = (state_d == GRANT_A) ? OWN_A : OWN_B;
      grant_count_d = grant_count_q + 8'd1;
    end
    // hold_cnt counts the cycles already spent in the current grant.
    if (state_q == state_d && (state_q == GRANT_A || state_q == GRANT_B))
      hold_cnt_d = hold_cnt_q + 8'd1;
  end

  assign bus.grant_a     = grant_a_q;
  assign bus.grant_b     = grant_b_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;
  assign bus.grant_count = grant_count_q;

endmodule
